// File: rtl/esteira_pkg.sv
// Shared conveyor definitions: state encoding, default timings and dozen size.
// Also used by the cork counter and the filling stage.
package esteira_pkg;

  typedef enum logic [2:0] {
    ST_PARADO    = 3'd0,
    ST_ESTEIRA   = 3'd1,
    ST_POSICIONA = 3'd2,
    ST_SEM_ROLHA = 3'd3,
    ST_VEDA      = 3'd4,
    ST_LIBERA    = 3'd5,
    ST_FALHA     = 3'd6
  } estado_t;

  localparam int T_ASSENTO_PAD    = 4;
  localparam int T_VEDA_PAD       = 8;
  localparam int T_LIBERA_MAX_PAD = 15;
  localparam int DUZIA            = 12;

endpackage

// File: rtl/controle_vedacao_temporizador.sv
// 4-bit loadable down-counter that stops at zero; zero flag comes straight from the register.
module temporizador (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] valor,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = valor;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/controle_vedacao.sv
// Corking-station controller: stops the belt at the corker, requests a cork, seals, releases,
// and counts sealed bottles in units and dozens.
module controle_vedacao
  import esteira_pkg::*;
#(
  parameter int T_ASSENTO    = T_ASSENTO_PAD,
  parameter int T_VEDA       = T_VEDA_PAD,
  parameter int T_LIBERA_MAX = T_LIBERA_MAX_PAD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       liga,
  input  logic       sensor_vedacao,
  input  logic       rolha_disponivel,
  input  logic       disp_acionado,
  output logic       motor_esteira,
  output logic       dec,
  output logic       atuador_vedacao,
  output logic       alarme_sem_rolha,
  output logic       falha,
  output logic [3:0] garrafas,
  output logic [7:0] duzias
);

  localparam logic [3:0] V_ASSENTO = 4'(T_ASSENTO - 1);
  localparam logic [3:0] V_VEDA    = 4'(T_VEDA - 1);
  localparam logic [3:0] V_LIBERA  = 4'(T_LIBERA_MAX - 1);
  localparam logic [3:0] G_ULTIMA  = 4'(DUZIA - 1);

  estado_t    state_q, state_d;
  logic       motor_q, motor_d;
  logic       dec_q, dec_d;
  logic       atuador_q, atuador_d;
  logic       alarme_q, alarme_d;
  logic       falha_q, falha_d;
  logic [3:0] garrafas_q, garrafas_d;
  logic [7:0] duzias_q, duzias_d;

  logic       tmr_load;
  logic [3:0] tmr_valor;
  logic       tmr_zero;

  temporizador u_temporizador (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .valor (tmr_valor),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_valor  = 4'd0;
    dec_d      = 1'b0;
    garrafas_d = garrafas_q;
    duzias_d   = duzias_q;

    case (state_q)
      ST_PARADO: begin
        if (liga) state_d = ST_ESTEIRA;
      end
      ST_ESTEIRA: begin
        if (sensor_vedacao) begin
          state_d   = ST_POSICIONA;
          tmr_load  = 1'b1;
          tmr_valor = V_ASSENTO;
        end else if (!liga) begin
          state_d = ST_PARADO;
        end
      end
      ST_POSICIONA, ST_SEM_ROLHA: begin
        if (state_q == ST_POSICIONA && !sensor_vedacao) begin
          state_d = ST_ESTEIRA;
        end else if (state_q == ST_SEM_ROLHA || tmr_zero) begin
          // Hold off while the counter refills so the cork request is not swallowed.
          if (rolha_disponivel && !disp_acionado) begin
            state_d   = ST_VEDA;
            tmr_load  = 1'b1;
            tmr_valor = V_VEDA;
            dec_d     = 1'b1;
          end else if (!rolha_disponivel) begin
            state_d = ST_SEM_ROLHA;
          end
        end
      end
      ST_VEDA: begin
        if (tmr_zero) begin
          state_d   = ST_LIBERA;
          tmr_load  = 1'b1;
          tmr_valor = V_LIBERA;
          if (garrafas_q == G_ULTIMA) begin
            garrafas_d = 4'd0;
            duzias_d   = duzias_q + 8'd1;
          end else begin
            garrafas_d = garrafas_q + 4'd1;
          end
        end
      end
      ST_LIBERA: begin
        if (!sensor_vedacao) begin
          state_d = liga ? ST_ESTEIRA : ST_PARADO;
        end else if (tmr_zero) begin
          state_d = ST_FALHA;
        end
      end
      ST_FALHA: state_d = ST_FALHA;
      default:  state_d = ST_PARADO;
    endcase

    motor_d   = (state_d == ST_ESTEIRA) || (state_d == ST_LIBERA);
    atuador_d = (state_d == ST_VEDA);
    alarme_d  = (state_d == ST_SEM_ROLHA);
    falha_d   = (state_d == ST_FALHA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_PARADO;
      motor_q    <= 1'b0;
      dec_q      <= 1'b0;
      atuador_q  <= 1'b0;
      alarme_q   <= 1'b0;
      falha_q    <= 1'b0;
      garrafas_q <= 4'd0;
      duzias_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      motor_q    <= motor_d;
      dec_q      <= dec_d;
      atuador_q  <= atuador_d;
      alarme_q   <= alarme_d;
      falha_q    <= falha_d;
      garrafas_q <= garrafas_d;
      duzias_q   <= duzias_d;
    end
  end

  assign motor_esteira    = motor_q;
  assign dec              = dec_q;
  assign atuador_vedacao  = atuador_q;
  assign alarme_sem_rolha = alarme_q;
  assign falha            = falha_q;
  assign garrafas         = garrafas_q;
  assign duzias           = duzias_q;

endmodule

// File: tb/tb_controle_vedacao.sv
// Directed bench for controle_vedacao: per-cycle vector table plus hand-written corner sequences.
module tb_controle_vedacao;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       liga = 1'b0;
  logic       sensor_vedacao = 1'b0;
  logic       rolha_disponivel = 1'b1;
  logic       disp_acionado = 1'b0;
  logic       motor_esteira;
  logic       dec;
  logic       atuador_vedacao;
  logic       alarme_sem_rolha;
  logic       falha;
  logic [3:0] garrafas;
  logic [7:0] duzias;

  int checks = 0;
  int errors = 0;

  controle_vedacao dut (
    .clk              (clk),
    .reset            (reset),
    .liga             (liga),
    .sensor_vedacao   (sensor_vedacao),
    .rolha_disponivel (rolha_disponivel),
    .disp_acionado    (disp_acionado),
    .motor_esteira    (motor_esteira),
    .dec              (dec),
    .atuador_vedacao  (atuador_vedacao),
    .alarme_sem_rolha (alarme_sem_rolha),
    .falha            (falha),
    .garrafas         (garrafas),
    .duzias           (duzias)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {motor, dec, atuador, alarme, falha, garrafas[3:0]}.
  typedef struct {
    logic       liga;
    logic       sens;
    logic       rolha;
    logic       disp;
    logic [8:0] exp;
  } vec_t;

  vec_t tab[$];

  function automatic void push(input logic l, input logic s, input logic r, input logic d,
                               input logic m, input logic dc, input logic a, input logic al,
                               input logic f, input logic [3:0] g);
    vec_t v;
    v.liga  = l;
    v.sens  = s;
    v.rolha = r;
    v.disp  = d;
    v.exp   = {m, dc, a, al, f, g};
    tab.push_back(v);
  endfunction

  function automatic logic [8:0] outs();
    return {motor_esteira, dec, atuador_vedacao, alarme_sem_rolha, falha, garrafas};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_bottle();
    sensor_vedacao = 1'b1;
    repeat (13) tick();
    sensor_vedacao = 1'b0;
    tick();
  endtask

  initial begin
    // Nominal bottle: sensor high for 19 steps
    push(1,0,1,0, 1,0,0,0,0,4'd0);
    for (int i = 0; i < 4; i++) push(1,1,1,0, 0,0,0,0,0,4'd0);
    push(1,1,1,0, 0,1,1,0,0,4'd0);
    for (int i = 0; i < 7; i++) push(1,1,1,0, 0,0,1,0,0,4'd0);
    for (int i = 0; i < 7; i++) push(1,1,1,0, 1,0,0,0,0,4'd1);
    push(1,0,1,0, 1,0,0,0,0,4'd1);
    // Sensor glitch
    for (int i = 0; i < 2; i++) push(1,1,1,0, 0,0,0,0,0,4'd1);
    for (int i = 0; i < 2; i++) push(1,0,1,0, 1,0,0,0,0,4'd1);
    // No cork at seating
    for (int i = 0; i < 4; i++) push(1,1,0,0, 0,0,0,0,0,4'd1);
    for (int i = 0; i < 2; i++) push(1,1,0,0, 0,0,0,1,0,4'd1);
    push(1,1,1,0, 0,1,1,0,0,4'd1);
    for (int i = 0; i < 7; i++) push(1,1,1,0, 0,0,1,0,0,4'd1);
    push(1,1,1,0, 1,0,0,0,0,4'd2);
    push(1,0,1,0, 1,0,0,0,0,4'd2);
    // Refill pulse on VEDA entry, liga dropped mid-seal
    for (int i = 0; i < 4; i++) push(1,1,1,0, 0,0,0,0,0,4'd2);
    push(1,1,1,1, 0,0,0,0,0,4'd2);
    push(1,1,1,0, 0,1,1,0,0,4'd2);
    for (int i = 0; i < 7; i++) push(0,1,1,0, 0,0,1,0,0,4'd2);
    push(0,1,1,0, 1,0,0,0,0,4'd3);
    push(0,0,1,0, 0,0,0,0,0,4'd3);
    push(0,1,1,0, 0,0,0,0,0,4'd3);
    push(1,0,1,0, 1,0,0,0,0,4'd3);

    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_duzias", 32'(duzias), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("idle_parado", 32'(outs()), 32'd0);

    for (int i = 0; i < tab.size(); i++) begin
      liga             = tab[i].liga;
      sensor_vedacao   = tab[i].sens;
      rolha_disponivel = tab[i].rolha;
      disp_acionado    = tab[i].disp;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tab[i].exp));
    end

    // Dozen rollover: garrafas 11->0 and duzias 0->1 on the same edge
    liga = 1'b1; rolha_disponivel = 1'b1; disp_acionado = 1'b0;
    repeat (8) run_bottle();
    chk("g_before_wrap", 32'(garrafas), 32'd11);
    sensor_vedacao = 1'b1;
    repeat (12) tick();
    chk("last_veda_g", 32'({duzias, garrafas}), 32'({8'd0, 4'd11}));
    tick();
    chk("wrap_g_d", 32'({duzias, garrafas}), 32'({8'd1, 4'd0}));
    sensor_vedacao = 1'b0;
    tick();

    // Drive duzias up to 255, then one more dozen wraps it to 0
    repeat (254 * 12) run_bottle();
    chk("duzias_255", 32'({duzias, garrafas}), 32'({8'd255, 4'd0}));
    repeat (12) run_bottle();
    chk("duzias_wrap", 32'({duzias, garrafas}), 32'({8'd0, 4'd0}));

    // Sensor stuck high in LIBERA
    sensor_vedacao = 1'b1;
    repeat (13) tick();
    repeat (14) tick();
    chk("libera_last", 32'(outs()), 32'({5'b10000, 4'd1}));
    tick();
    chk("falha_set", 32'(outs()), 32'({5'b00001, 4'd1}));
    sensor_vedacao = 1'b0;
    liga = 1'b0;
    repeat (3) tick();
    liga = 1'b1;
    repeat (3) tick();
    chk("falha_sticky", 32'(outs()), 32'({5'b00001, 4'd1}));
    #2;
    reset = 1'b1;
    #1;
    chk("falha_reset", 32'(outs()), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset in the middle of a seal
    tick();
    chk("esteira_again", 32'(motor_esteira), 32'd1);
    sensor_vedacao = 1'b1;
    repeat (7) tick();
    chk("mid_veda", 32'(outs()), 32'({5'b00100, 4'd0}));
    #2;
    reset = 1'b1;
    #1;
    chk("veda_reset", 32'(outs()), 32'd0);
    sensor_vedacao = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) tick();
    chk("no_count_after_reset", 32'(garrafas), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
